// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU-control pipeline stage: op classes, ALU codes, FSM states,
// func7 encodings and the base func3 -> ALU code mapping.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LS  = 2'b00,
    OP_BR  = 2'b01,
    OP_R   = 2'b10,
    OP_I   = 2'b11
  } alu_op_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_SRA    = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_WAIT  = 2'b01,
    S_FULL  = 2'b10
  } state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // alt selects the SUB/SRA variants of func3 000/101
  function automatic alu_ctrl_e base_code(input logic [2:0] f3, input logic alt);
    alu_ctrl_e code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/func3/func7 into ALU code, branch invert, illegal,
// and multi-cycle class. RV32M decode is present only when M_EXT_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output logic [4:0] o_ctrl,
  output logic       o_br_inv,
  output logic       o_illegal,
  output logic       o_multi,
  output logic       o_lat_sel
);

  alu_ctrl_e w_code;
  logic      w_bad;

  // Decode tables; any undefined encoding collapses to a single-cycle ADD flagged illegal
  always_comb begin
    w_code    = ALU_ADD;
    w_bad     = 1'b0;
    o_br_inv  = 1'b0;
    o_multi   = 1'b0;
    o_lat_sel = 1'b0;
    case (alu_op_e'(i_alu_op))
      OP_LS: w_code = ALU_ADD;
      OP_BR: begin
        case (i_func3)
          3'b000, 3'b001: begin w_code = ALU_SUB;  o_br_inv = i_func3[0]; end
          3'b100, 3'b101: begin w_code = ALU_SLT;  o_br_inv = i_func3[0]; end
          3'b110, 3'b111: begin w_code = ALU_SLTU; o_br_inv = i_func3[0]; end
          default:        w_bad = 1'b1;
        endcase
      end
      OP_R: begin
        if (i_func7 == F7_BASE) begin
          w_code = base_code(i_func3, 1'b0);
        end else if ((i_func7 == F7_ALT) && ((i_func3 == 3'b000) || (i_func3 == 3'b101))) begin
          w_code = base_code(i_func3, 1'b1);
`ifdef M_EXT_EN
        end else if (i_func7 == F7_MEXT) begin
          w_code    = alu_ctrl_e'({2'b10, i_func3});
          o_multi   = 1'b1;
          o_lat_sel = i_func3[2];
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      OP_I: begin
        case (i_func3)
          3'b001: begin
            if (i_func7 == F7_BASE) w_code = ALU_SLL;
            else                    w_bad  = 1'b1;
          end
          3'b101: begin
            if (i_func7 == F7_BASE)     w_code = ALU_SRL;
            else if (i_func7 == F7_ALT) w_code = ALU_SRA;
            else                        w_bad  = 1'b1;
          end
          default: w_code = base_code(i_func3, 1'b0);
        endcase
      end
      default: w_bad = 1'b1;
    endcase

    o_illegal = w_bad;
    if (w_bad) begin
      o_ctrl    = ALU_ADD;
      o_br_inv  = 1'b0;
      o_multi   = 1'b0;
      o_lat_sel = 1'b0;
    end else begin
      o_ctrl = w_code;
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ID->EX ALU-control stage with valid/ready handshakes and a multi-cycle hold
// for MUL/DIV ops. Define M_EXT_EN to enable RV32M decode; otherwise S_WAIT is unreachable.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_func3,
  input  logic [6:0]       in_func7,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu_ctrl,
  output logic             out_br_inv,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [4:0]       r_alu_ctrl;
  logic             r_br_inv;
  logic             r_illegal;
  logic [TAG_W-1:0] r_tag;

  logic [4:0]       w_ctrl;
  logic             w_br_inv;
  logic             w_illegal;
  logic             w_multi;
  logic             w_lat_sel;
  logic [CNT_W-1:0] w_lat;
  logic             w_go_wait;
  logic             w_in_ready;
  logic             w_accept;

  alu_ctrl_decode u_decode (
    .i_alu_op  (in_alu_op),
    .i_func3   (in_func3),
    .i_func7   (in_func7),
    .o_ctrl    (w_ctrl),
    .o_br_inv  (w_br_inv),
    .o_illegal (w_illegal),
    .o_multi   (w_multi),
    .o_lat_sel (w_lat_sel)
  );

  assign w_in_ready = (r_state == S_EMPTY) || ((r_state == S_FULL) && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_lat      = w_lat_sel ? DIV_L : MUL_L;
  assign w_go_wait  = w_multi && (w_lat != {CNT_W{1'b0}});

  // Stage FSM and output registers; flush outranks every other update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= 5'b00000;
      r_br_inv    <= 1'b0;
      r_illegal   <= 1'b0;
      r_tag       <= {TAG_W{1'b0}};
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY, S_FULL: begin
          if (w_accept) begin
            r_alu_ctrl <= w_ctrl;
            r_br_inv   <= w_br_inv;
            r_illegal  <= w_illegal;
            r_tag      <= in_tag;
            if (w_go_wait) begin
              r_state     <= S_WAIT;
              r_cnt       <= w_lat - CNT_W'(1);
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= S_FULL;
              r_cnt       <= {CNT_W{1'b0}};
              r_out_valid <= 1'b1;
            end
          end else if ((r_state == S_FULL) && out_ready) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_WAIT: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state     <= S_FULL;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_cnt       <= {CNT_W{1'b0}};
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_alu_ctrl = r_alu_ctrl;
  assign out_br_inv   = r_br_inv;
  assign out_illegal  = r_illegal;
  assign out_tag      = r_tag;
`ifdef M_EXT_EN
  assign busy = (r_state == S_WAIT);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed, table-driven bench for alu_ctrl_stage; M-extension sequences follow M_EXT_EN.
module tb_alu_ctrl_stage;

  localparam int TAG_W   = 5;
  localparam int DIV_LAT = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_alu_op = 2'b00;
  logic [2:0]       in_func3 = 3'b000;
  logic [6:0]       in_func7 = 7'b0000000;
  logic [TAG_W-1:0] in_tag = 5'd0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [4:0]       out_alu_ctrl;
  logic             out_br_inv;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_total = 0;
  int n_pass  = 0;

  alu_ctrl_stage #(.TAG_W(TAG_W), .MUL_LAT(2), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_func3(in_func3), .in_func7(in_func7), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_br_inv(out_br_inv), .out_illegal(out_illegal),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] ctrl;
    logic       br;
    logic       ill;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] tag);
    in_valid  = 1'b1;
    in_alu_op = op;
    in_func3  = f3;
    in_func7  = f7;
    in_tag    = tag;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [4:0] c,
                         input logic ill, input logic [4:0] tag);
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, ".ctrl"}, {27'd0, out_alu_ctrl}, {27'd0, c});
    chk({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    chk({name, ".tag"}, {27'd0, out_tag}, {27'd0, tag});
  endtask

  task automatic chk_reset_vals(input string name);
    chk_out(name, 1'b0, 5'b00000, 1'b0, 5'd0);
    chk({name, ".br_inv"}, {31'd0, out_br_inv}, 32'd0);
    chk({name, ".busy"}, {31'd0, busy}, 32'd0);
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 3'b010, 7'b0000000, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 3'b000, 7'b0000000, 5'b01000, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 3'b001, 7'b0000000, 5'b01000, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 3'b101, 7'b0000000, 5'b00010, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 3'b111, 7'b0000000, 5'b00011, 1'b1, 1'b0};
    vecs[5]  = '{2'b01, 3'b110, 7'b0000000, 5'b00011, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 3'b010, 7'b0000000, 5'b00000, 1'b0, 1'b1};
    vecs[7]  = '{2'b10, 3'b000, 7'b0000000, 5'b00000, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 3'b000, 7'b0100000, 5'b01000, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 3'b101, 7'b0100000, 5'b01101, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 3'b001, 7'b0000000, 5'b00001, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 3'b111, 7'b0000000, 5'b00111, 1'b0, 1'b0};
    vecs[12] = '{2'b10, 3'b001, 7'b0100000, 5'b00000, 1'b0, 1'b1};
    vecs[13] = '{2'b10, 3'b000, 7'b0010000, 5'b00000, 1'b0, 1'b1};
    vecs[14] = '{2'b11, 3'b101, 7'b0100000, 5'b01101, 1'b0, 1'b0};
    vecs[15] = '{2'b11, 3'b101, 7'b0010000, 5'b00000, 1'b0, 1'b1};
    vecs[16] = '{2'b11, 3'b001, 7'b0000000, 5'b00001, 1'b0, 1'b0};
    vecs[17] = '{2'b11, 3'b001, 7'b0100000, 5'b00000, 1'b0, 1'b1};
    vecs[18] = '{2'b11, 3'b000, 7'b1111111, 5'b00000, 1'b0, 1'b0};
    vecs[19] = '{2'b11, 3'b110, 7'b0000000, 5'b00110, 1'b0, 1'b0};
    vecs[20] = '{2'b11, 3'b100, 7'b0000000, 5'b00100, 1'b0, 1'b0};
    vecs[21] = '{2'b11, 3'b011, 7'b0000000, 5'b00011, 1'b0, 1'b0};
    vecs[22] = '{2'b10, 3'b110, 7'b0000000, 5'b00110, 1'b0, 1'b0};
    vecs[23] = '{2'b10, 3'b010, 7'b0000000, 5'b00010, 1'b0, 1'b0};

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // back-to-back decode table with out_ready held high
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'(i));
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].ctrl, vecs[i].ill, 5'(i));
      chk($sformatf("vec%0d.br_inv", i), {31'd0, out_br_inv}, {31'd0, vecs[i].br});
    end
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // out_ready toggles 1,0,1 across ADD/SUB/XOR
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 7'b0000000, 5'd1);
    tick();
    chk_out("hold.add", 1'b1, 5'b00000, 1'b0, 5'd1);
    drive(2'b10, 3'b000, 7'b0100000, 5'd2);
    out_ready = 1'b0;
    #1;
    chk("hold.in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("hold.stalled", 1'b1, 5'b00000, 1'b0, 5'd1);
    out_ready = 1'b1;
    tick();
    chk_out("hold.sub", 1'b1, 5'b01000, 1'b0, 5'd2);
    drive(2'b10, 3'b100, 7'b0000000, 5'd3);
    tick();
    chk_out("hold.xor", 1'b1, 5'b00100, 1'b0, 5'd3);
    in_valid = 1'b0;
    tick();
    chk("hold.empty", {31'd0, out_valid}, 32'd0);

    // flush drops a same-cycle op
    drive(2'b10, 3'b000, 7'b0000000, 5'd5);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush.dropped", {31'd0, out_valid}, 32'd0);

`ifdef M_EXT_EN
    // DIV holds for DIV_LAT edges
    drive(2'b10, 3'b100, 7'b0000001, 5'd9);
    tick();
    in_valid = 1'b1;
    in_func7 = 7'b0000000;
    for (int k = 0; k < DIV_LAT; k++) begin
      chk($sformatf("div.busy%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("div.in_ready%0d", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("div.valid%0d", k), {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk_out("div.done", 1'b1, 5'b10100, 1'b0, 5'd9);
    chk("div.busy_done", {31'd0, busy}, 32'd0);

    // MULHU holds for 2 edges
    drive(2'b10, 3'b011, 7'b0000001, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("mul.busy0", {31'd0, busy}, 32'd1);
    tick();
    chk("mul.busy1", {31'd0, busy}, 32'd1);
    tick();
    chk_out("mul.done", 1'b1, 5'b10011, 1'b0, 5'd4);

    // async reset in the middle of a DIV hold
    drive(2'b10, 3'b100, 7'b0000001, 5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rstwait.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstwait");
`else
    // without RV32M, func7=0000001 is a single-cycle illegal ADD
    drive(2'b10, 3'b100, 7'b0000001, 5'd9);
    tick();
    in_valid = 1'b0;
    chk_out("noM.div", 1'b1, 5'b00000, 1'b1, 5'd9);
    chk("noM.busy", {31'd0, busy}, 32'd0);

    // async reset while holding a valid op
    drive(2'b11, 3'b100, 7'b0000000, 5'd7);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_out("rstfull.pre", 1'b1, 5'b00100, 1'b0, 5'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstfull");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Registered, parametrised successor of the combinational ALU-control decoder. Sits between ID and EX as one pipeline stage with valid/ready handshakes on both sides. Decodes alu_op/func3/func7 into a 5-bit ALU control code, a branch-invert flag and an illegal flag. Adds I-type shift decode, optional RV32M decode, and a multi-cycle hold for MUL/DIV ops.

Parameters:
TAG_W, 5, width of the opaque tag (e.g. rd index) passed through with each op
MUL_LAT, 2, extra cycles held for MUL-family ops; 0 means single-cycle
DIV_LAT, 32, extra cycles held for DIV/REM-family ops; 0 means single-cycle

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID presents an op
in_ready  out  1  stage can accept; combinational from state and out_ready
in_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
in_func3  in  3  instruction func3
in_func7  in  7  instruction func7
in_tag  in  TAG_W  passthrough tag
flush  in  1  synchronous kill of stage contents
out_valid  out  1  registered op valid to EX
out_ready  in  1  EX accepts
out_alu_ctrl  out  5  ALU control code
out_br_inv  out  1  invert compare result (BNE/BGE/BGEU)
out_illegal  out  1  undefined encoding; out_alu_ctrl forced to ADD
out_tag  out  TAG_W  tag of the held op
busy  out  1  high while in S_WAIT

Behaviour:
- Reset: state S_EMPTY, cnt=0; out_valid, out_alu_ctrl, out_br_inv, out_illegal, out_tag and busy all 0. in_ready=1 in S_EMPTY.
- Decode:
  - 00: ADD.
  - 01: func3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU. br_inv=1 for 001/101/111. func3 010/011 -> illegal.
  - 10: {func7[5],func3} gives the same codes as the base table. Any func7 other than 0000000, or 0100000 with func3 000/101, is illegal.
  - 11: ADDI/SLTI/SLTIU/XORI/ORI/ANDI. SLLI requires func3 001 with func7=0000000. SRLI/SRAI require func3 101 with func7 0000000/0100000. Any other func7 on a shift is illegal.
- Codes: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
- FSM:
  - S_EMPTY: in_ready=1. On accept, multi-cycle op with LAT>0 -> S_WAIT with cnt=LAT-1; otherwise -> S_FULL.
  - S_WAIT: out_valid=0, in_ready=0, busy=1. Each edge: cnt==0 -> S_FULL, else cnt-1.
  - S_FULL: out_valid=1, in_ready=out_ready. out_ready&in_valid loads the next op (to S_FULL or S_WAIT). out_ready&!in_valid -> S_EMPTY. !out_ready holds all outputs stable.
- Latency: single-cycle op accepted at edge N shows out_valid after edge N. Multi-cycle op shows out_valid after edge N+LAT.
- Outputs change only on accept. An illegal op still flows through with out_illegal=1 and is always single-cycle.
- flush has priority over everything. Next state is S_EMPTY, out_valid=0, cnt=0. A same-cycle in_valid is dropped, and in_ready stays as computed (the dropped op is considered consumed).
- Async reset mid-S_WAIT returns to the reset values immediately.
- cnt width: $clog2(max(MUL_LAT,DIV_LAT)+1), minimum 1.

Optional Feature:
M_EXT_EN:
- Defined: alu_op 10 with func7=0000001 decodes to MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011 (latency MUL_LAT), and DIV 10100, DIVU 10101, REM 10110, REMU 10111 (latency DIV_LAT).
- Undefined: func7=0000001 is illegal (ADD, single-cycle), S_WAIT is unreachable, and busy is tied to 0.

Decomposition:
- Package alu_ctrl_pkg holds the alu_op_e enum, the 5-bit alu_ctrl_e code enum, the FSM state enum, and the func7 constants F7_BASE/F7_ALT/F7_MEXT.
- Sub-module alu_ctrl_decode: pure combinational decode to {ctrl, br_inv, illegal, multi, lat_sel}. The stage instantiates it and owns the FSM and registers.

Test Plan:
- Reset mid-S_WAIT after a DIV → all outputs 0, in_ready=1.
- R-type func7=0100000, func3=101, out_ready=1 → after 1 edge: out_valid=1, ctrl=01101, illegal=0.
- I-type func3=101, func7=0100000 → ctrl=01101. Same with func7=0010000 → illegal=1, ctrl=00000.
- Branch func3=111 → ctrl=00011, br_inv=1. func3=010 → illegal=1.
- M_EXT_EN, DIV_LAT=32, func7=0000001, func3=100:
  - busy is high for 32 edges with in_ready=0.
  - out_valid rises after edge N+32 with ctrl=10100 and the correct tag.
  - Without M_EXT_EN: illegal=1 after 1 edge.
- Back-to-back ADD/SUB/XOR with out_ready toggling 1,0,1:
  - outputs hold while out_ready=0; no op is lost or duplicated.
  - flush asserted with in_valid=1 gives out_valid=0 next cycle and the op is dropped.
